// File: rtl/dispatch_busytable.sv
// Dispatch stage: looks up operand busy state for the renamed instruction and
// registers it in a one-entry valid/ready stage feeding the issue queue enqueue port.
module dispatch_busytable #(
  parameter int PREG_W       = 6,
  parameter int NUM_PREG     = 64,
  parameter int ROB_SIZE_LOG = 6,
  parameter int PAYLOAD_W    = 128
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rn_valid,
  output logic                    rn_ready,
  input  logic [PREG_W-1:0]       rn_prs1,
  input  logic [PREG_W-1:0]       rn_prs2,
  input  logic [PREG_W-1:0]       rn_prd,
  input  logic                    rn_src1_is_reg,
  input  logic                    rn_src2_is_reg,
  input  logic                    rn_need_to_wb,
  input  logic                    rn_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] rn_robidx,
  input  logic [PAYLOAD_W-1:0]    rn_payload,
  output logic                    enq_instr0_valid,
  input  logic                    enq_instr0_ready,
  output logic [PREG_W-1:0]       enq_instr0_prs1,
  output logic [PREG_W-1:0]       enq_instr0_prs2,
  output logic [PREG_W-1:0]       enq_instr0_prd,
  output logic                    enq_instr0_src1_is_reg,
  output logic                    enq_instr0_src2_is_reg,
  output logic                    enq_instr0_need_to_wb,
  output logic                    enq_instr0_src1_state,
  output logic                    enq_instr0_src2_state,
  output logic                    enq_instr0_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] enq_instr0_robidx,
  output logic [PAYLOAD_W-1:0]    enq_instr0_payload,
  input  logic                    writeback0_valid,
  input  logic                    writeback0_need_to_wb,
  input  logic [PREG_W-1:0]       writeback0_prd,
  input  logic                    writeback1_valid,
  input  logic                    writeback1_need_to_wb,
  input  logic [PREG_W-1:0]       writeback1_prd,
  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx
);

  logic [NUM_PREG-1:0] busy;
  logic [NUM_PREG-1:0] busy_set;
  logic [NUM_PREG-1:0] busy_clr;
  logic [NUM_PREG-1:0] busy_nxt;
  logic                accept;
  logic                held_younger;
  logic                rn_src1_state;
  logic                rn_src2_state;

  function automatic logic wb_hit(input logic [PREG_W-1:0] p);
    return (writeback0_valid & writeback0_need_to_wb & (writeback0_prd == p)) |
           (writeback1_valid & writeback1_need_to_wb & (writeback1_prd == p));
  endfunction

  assign rn_ready = ~flush_valid & (~enq_instr0_valid | enq_instr0_ready);
  assign accept   = rn_valid & rn_ready;

  // Same-cycle writeback bypass so a just-woken operand is never reported busy.
  assign rn_src1_state = rn_src1_is_reg & (rn_prs1 != '0) & busy[rn_prs1] & ~wb_hit(rn_prs1);
  assign rn_src2_state = rn_src2_is_reg & (rn_prs2 != '0) & busy[rn_prs2] & ~wb_hit(rn_prs2);

  assign held_younger = (flush_robidx_flag ^ enq_instr0_robidx_flag) ^
                        (flush_robidx < enq_instr0_robidx);

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (accept && rn_need_to_wb && (rn_prd != '0))
      busy_set[rn_prd] = 1'b1;
    if (writeback0_valid && writeback0_need_to_wb)
      busy_clr[writeback0_prd] = 1'b1;
    if (writeback1_valid && writeback1_need_to_wb)
      busy_clr[writeback1_prd] = 1'b1;
    // Allocation wins over a clear of the same preg in the same cycle.
    busy_nxt    = (busy & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      enq_instr0_valid <= 1'b0;
    else if (accept)
      enq_instr0_valid <= 1'b1;
    else if (enq_instr0_valid && flush_valid && held_younger)
      enq_instr0_valid <= 1'b0;
    else if (enq_instr0_valid && enq_instr0_ready)
      enq_instr0_valid <= 1'b0;
  end

  // Payload flops carry no reset; a held entry keeps tracking wakeups.
  always_ff @(posedge clock) begin
    if (accept) begin
      enq_instr0_prs1        <= rn_prs1;
      enq_instr0_prs2        <= rn_prs2;
      enq_instr0_prd         <= rn_prd;
      enq_instr0_src1_is_reg <= rn_src1_is_reg;
      enq_instr0_src2_is_reg <= rn_src2_is_reg;
      enq_instr0_need_to_wb  <= rn_need_to_wb;
      enq_instr0_src1_state  <= rn_src1_state;
      enq_instr0_src2_state  <= rn_src2_state;
      enq_instr0_robidx_flag <= rn_robidx_flag;
      enq_instr0_robidx      <= rn_robidx;
      enq_instr0_payload     <= rn_payload;
    end else begin
      if (enq_instr0_src1_is_reg && wb_hit(enq_instr0_prs1))
        enq_instr0_src1_state <= 1'b0;
      if (enq_instr0_src2_is_reg && wb_hit(enq_instr0_prs2))
        enq_instr0_src2_state <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dispatch_busytable.sv
// Directed bench for dispatch_busytable: busy lookup, bypasses, backpressure,
// flush age comparison and asynchronous reset.
module tb_dispatch_busytable;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         rn_valid;
  logic         rn_ready;
  logic [5:0]   rn_prs1, rn_prs2, rn_prd;
  logic         rn_src1_is_reg, rn_src2_is_reg, rn_need_to_wb;
  logic         rn_robidx_flag;
  logic [5:0]   rn_robidx;
  logic [127:0] rn_payload;
  logic         enq_instr0_valid, enq_instr0_ready;
  logic [5:0]   enq_instr0_prs1, enq_instr0_prs2, enq_instr0_prd;
  logic         enq_instr0_src1_is_reg, enq_instr0_src2_is_reg, enq_instr0_need_to_wb;
  logic         enq_instr0_src1_state, enq_instr0_src2_state;
  logic         enq_instr0_robidx_flag;
  logic [5:0]   enq_instr0_robidx;
  logic [127:0] enq_instr0_payload;
  logic         writeback0_valid, writeback0_need_to_wb;
  logic [5:0]   writeback0_prd;
  logic         writeback1_valid, writeback1_need_to_wb;
  logic [5:0]   writeback1_prd;
  logic         flush_valid, flush_robidx_flag;
  logic [5:0]   flush_robidx;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dispatch_busytable dut (
    .clock(clock), .reset_n(reset_n),
    .rn_valid(rn_valid), .rn_ready(rn_ready),
    .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_prd(rn_prd),
    .rn_src1_is_reg(rn_src1_is_reg), .rn_src2_is_reg(rn_src2_is_reg),
    .rn_need_to_wb(rn_need_to_wb), .rn_robidx_flag(rn_robidx_flag),
    .rn_robidx(rn_robidx), .rn_payload(rn_payload),
    .enq_instr0_valid(enq_instr0_valid), .enq_instr0_ready(enq_instr0_ready),
    .enq_instr0_prs1(enq_instr0_prs1), .enq_instr0_prs2(enq_instr0_prs2),
    .enq_instr0_prd(enq_instr0_prd),
    .enq_instr0_src1_is_reg(enq_instr0_src1_is_reg),
    .enq_instr0_src2_is_reg(enq_instr0_src2_is_reg),
    .enq_instr0_need_to_wb(enq_instr0_need_to_wb),
    .enq_instr0_src1_state(enq_instr0_src1_state),
    .enq_instr0_src2_state(enq_instr0_src2_state),
    .enq_instr0_robidx_flag(enq_instr0_robidx_flag),
    .enq_instr0_robidx(enq_instr0_robidx),
    .enq_instr0_payload(enq_instr0_payload),
    .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
    .writeback0_prd(writeback0_prd),
    .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
    .writeback1_prd(writeback1_prd),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag),
    .flush_robidx(flush_robidx)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] payloadOf(input logic [5:0] prd, input logic [5:0] idx);
    return {32'hC0DE_F00D, 80'h0, 8'(prd), 8'(idx)};
  endfunction

  task automatic applyStimulus(input logic [5:0] prs1, input logic [5:0] prs2,
                               input logic [5:0] prd, input logic wb,
                               input logic flag, input logic [5:0] idx);
    rn_valid       = 1'b1;
    rn_prs1        = prs1;
    rn_prs2        = prs2;
    rn_prd         = prd;
    rn_src1_is_reg = 1'b1;
    rn_src2_is_reg = 1'b1;
    rn_need_to_wb  = wb;
    rn_robidx_flag = flag;
    rn_robidx      = idx;
    rn_payload     = payloadOf(prd, idx);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    rn_valid = 0; rn_prs1 = 0; rn_prs2 = 0; rn_prd = 0;
    rn_src1_is_reg = 0; rn_src2_is_reg = 0; rn_need_to_wb = 0;
    rn_robidx_flag = 0; rn_robidx = 0; rn_payload = '0;
    enq_instr0_ready = 1'b1;
    writeback0_valid = 0; writeback0_need_to_wb = 0; writeback0_prd = 0;
    writeback1_valid = 0; writeback1_need_to_wb = 0; writeback1_prd = 0;
    flush_valid = 0; flush_robidx_flag = 0; flush_robidx = 0;

    #12;
    checkOutput("reset_valid", enq_instr0_valid, 1'b0);
    checkOutput("reset_rn_ready", rn_ready, 1'b1);
    reset_n = 1'b1;

    // A: idle operands, allocates prd 10
    applyStimulus(6'd5, 6'd6, 6'd10, 1'b1, 1'b0, 6'd1);
    #1 checkOutput("A_rn_ready", rn_ready, 1'b1);
    tick();
    checkOutput("A_valid", enq_instr0_valid, 1'b1);
    checkOutput("A_prs1", enq_instr0_prs1, 6'd5);
    checkOutput("A_prs2", enq_instr0_prs2, 6'd6);
    checkOutput("A_prd", enq_instr0_prd, 6'd10);
    checkOutput("A_s1", enq_instr0_src1_state, 1'b0);
    checkOutput("A_s2", enq_instr0_src2_state, 1'b0);
    checkOutput("A_payload", enq_instr0_payload, payloadOf(6'd10, 6'd1));

    // B depends on prd 10, then is woken while held
    applyStimulus(6'd10, 6'd5, 6'd11, 1'b1, 1'b0, 6'd2);
    tick();
    checkOutput("B_prd", enq_instr0_prd, 6'd11);
    checkOutput("B_s1_busy", enq_instr0_src1_state, 1'b1);
    checkOutput("B_s2", enq_instr0_src2_state, 1'b0);
    rn_valid = 0; enq_instr0_ready = 0;
    writeback0_valid = 1; writeback0_need_to_wb = 1; writeback0_prd = 6'd10;
    tick();
    writeback0_valid = 0; writeback0_need_to_wb = 0;
    checkOutput("B_held_valid", enq_instr0_valid, 1'b1);
    checkOutput("B_held_prd", enq_instr0_prd, 6'd11);
    checkOutput("B_s1_woken", enq_instr0_src1_state, 1'b0);

    // C: same-cycle wb1 bypass on prs1=11, prs2=0 reads ready
    enq_instr0_ready = 1;
    applyStimulus(6'd11, 6'd0, 6'd13, 1'b1, 1'b0, 6'd3);
    writeback1_valid = 1; writeback1_need_to_wb = 1; writeback1_prd = 6'd11;
    tick();
    writeback1_valid = 0; writeback1_need_to_wb = 0;
    checkOutput("C_prd", enq_instr0_prd, 6'd13);
    checkOutput("C_s1_bypass", enq_instr0_src1_state, 1'b0);
    checkOutput("C_s2_preg0", enq_instr0_src2_state, 1'b0);

    // D: busy[10] was cleared, busy[13] is set
    applyStimulus(6'd10, 6'd13, 6'd14, 1'b0, 1'b0, 6'd4);
    tick();
    checkOutput("D_s1_cleared", enq_instr0_src1_state, 1'b0);
    checkOutput("D_s2_busy", enq_instr0_src2_state, 1'b1);

    // Backpressure for 3 cycles with E waiting
    enq_instr0_ready = 0;
    applyStimulus(6'd11, 6'd0, 6'd15, 1'b1, 1'b0, 6'd5);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("bp_rn_ready", rn_ready, 1'b0);
      tick();
      checkOutput("bp_valid", enq_instr0_valid, 1'b1);
      checkOutput("bp_prd", enq_instr0_prd, 6'd14);
      checkOutput("bp_payload", enq_instr0_payload, payloadOf(6'd14, 6'd4));
    end
    enq_instr0_ready = 1;
    #1 checkOutput("E_rn_ready", rn_ready, 1'b1);
    tick();
    checkOutput("E_prd", enq_instr0_prd, 6'd15);
    checkOutput("E_s1", enq_instr0_src1_state, 1'b0);

    // F: back-to-back, own-dest reads old busy value
    applyStimulus(6'd15, 6'd16, 6'd16, 1'b1, 1'b0, 6'd6);
    tick();
    checkOutput("F_prd", enq_instr0_prd, 6'd16);
    checkOutput("F_s1_busy", enq_instr0_src1_state, 1'b1);
    checkOutput("F_s2_owndest", enq_instr0_src2_state, 1'b0);
    applyStimulus(6'd16, 6'd0, 6'd17, 1'b0, 1'b0, 6'd7);
    tick();
    checkOutput("G_s1_busy", enq_instr0_src1_state, 1'b1);

    // Flush age comparisons
    applyStimulus(6'd1, 6'd2, 6'd18, 1'b0, 1'b0, 6'd9);
    tick();
    checkOutput("H_prd", enq_instr0_prd, 6'd18);
    rn_valid = 0; enq_instr0_ready = 0;
    flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 6'd9;
    tick();
    checkOutput("flush_equal_kept", enq_instr0_valid, 1'b1);
    flush_robidx = 6'd4;
    tick();
    checkOutput("flush_younger_drop", enq_instr0_valid, 1'b0);
    applyStimulus(6'd1, 6'd2, 6'd19, 1'b0, 1'b1, 6'd2);
    #1 checkOutput("flush_rn_ready", rn_ready, 1'b0);
    tick();
    checkOutput("flush_no_accept", enq_instr0_valid, 1'b0);
    flush_valid = 0;
    tick();
    checkOutput("I_valid", enq_instr0_valid, 1'b1);
    checkOutput("I_flag", enq_instr0_robidx_flag, 1'b1);
    rn_valid = 0;
    flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 6'd60;
    tick();
    flush_valid = 0;
    checkOutput("flush_wrap_drop", enq_instr0_valid, 1'b0);

    // J: set beats same-cycle clear of prd 12
    enq_instr0_ready = 1;
    applyStimulus(6'd0, 6'd0, 6'd12, 1'b1, 1'b0, 6'd10);
    writeback0_valid = 1; writeback0_need_to_wb = 1; writeback0_prd = 6'd12;
    tick();
    writeback0_valid = 0; writeback0_need_to_wb = 0;
    applyStimulus(6'd12, 6'd0, 6'd20, 1'b0, 1'b0, 6'd11);
    tick();
    checkOutput("K_s1_setwins", enq_instr0_src1_state, 1'b1);
    rn_valid = 0; enq_instr0_ready = 0;
    tick();
    checkOutput("K_held", enq_instr0_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1 checkOutput("async_reset_valid", enq_instr0_valid, 1'b0);
    #3 reset_n = 1'b1;
    enq_instr0_ready = 1;
    applyStimulus(6'd12, 6'd0, 6'd21, 1'b0, 1'b0, 6'd12);
    tick();
    checkOutput("L_valid", enq_instr0_valid, 1'b1);
    checkOutput("L_s1_busy_reset", enq_instr0_src1_state, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
